// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter; bit_end flags the last clock of the current period.
module uart_bit_timer #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             reload,
    input  logic [WIDTH-1:0] load_val,
    output logic             bit_end
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_count <= RST_VAL;
        else         r_count <= reload ? load_val : r_count - 1'b1;
    end
    assign bit_end = (r_count == '0);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 transmitter with a one-entry holding register for gap-free back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [UART_DATA_BITS-1:0] d_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LOAD = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(UART_DATA_BITS - 1);

    uart_state_e               r_state, w_next;
    logic [UART_DATA_BITS-1:0] r_hold, r_shift, w_shift_next;
    logic [IW-1:0]             r_idx, w_idx_next;
    logic                      r_hold_valid, r_tx;
    logic                      w_bit_end, w_reload, w_load, w_shift_en, w_done, w_tx, w_accept;
    logic [TW-1:0]             w_load_val;

    uart_bit_timer #(.WIDTH(TW), .RST_VAL(BIT_LOAD)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .reload   (w_reload),
        .load_val (w_load_val),
        .bit_end  (w_bit_end)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = r_hold_valid ? START : IDLE;
                w_load = r_hold_valid;
            end
            START: w_next = w_bit_end ? DATA : START;
            DATA: begin
                w_shift_en = w_bit_end;
                w_next     = (w_bit_end && r_idx == LAST_IDX) ? STOP : DATA;
            end
            STOP: begin
                w_done = w_bit_end;
                w_load = w_bit_end && r_hold_valid;
                w_next = !w_bit_end ? STOP : r_hold_valid ? START : IDLE;
            end
            default: w_next = IDLE;
        endcase
        w_reload     = (w_next != r_state) || w_bit_end;
        w_load_val   = (w_next == STOP) ? STOP_LOAD : BIT_LOAD;
        w_shift_next = w_load ? r_hold : w_shift_en ? {1'b0, r_shift[UART_DATA_BITS-1:1]} : r_shift;
        w_idx_next   = (r_state == START) ? '0 : w_shift_en ? r_idx + 1'b1 : r_idx;
        // line level is computed from the next state so tx_o comes straight off a flop
        w_tx         = (w_next == START) ? 1'b0 : (w_next == DATA) ? w_shift_next[0] : 1'b1;
    end

    assign w_accept = valid_i && ready_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_tx         <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold       <= d_i;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx;
        end
    end

    assign ready_o = !r_hold_valid;
    assign tx_o    = r_tx;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = w_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench driving an 8N1 and an 8N2 transmitter and decoding their serial lines.
module tb_uart_tx;
    localparam int C = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [7:0] d_s [2];
    logic valid_s [2];
    logic ready_s [2];
    logic tx_s [2];
    logic busy_s [2];
    logic done_s [2];
    int asserts = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] exp_q [2][$];
    int starts [2][$];
    int dones [2][$];
    int busy_cnt [2];
    int stray [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask

    // Reference line waveform: start low, data LSB first, stop high, each bit C samples.
    function automatic logic [43:0] exp_frame(input logic [7:0] b, input int fl);
        logic [43:0] e = '1;
        for (int i = 0; i < fl; i++) begin
            int p = i / C;
            e[i] = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : 1'b1;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int FL = (10 + g) * C;
        int n = 0;
        int done_n = 0;
        bit in_f = 1'b0;
        bit busy_ok = 1'b1;
        logic [43:0] act = '1;
        logic [7:0] b = '0;

        uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(g + 1)) dut (
            .clk     (clk),
            .resetn  (resetn),
            .d_i     (d_s[g]),
            .valid_i (valid_s[g]),
            .ready_o (ready_s[g]),
            .tx_o    (tx_s[g]),
            .busy_o  (busy_s[g]),
            .done_o  (done_s[g])
        );

        always @(negedge clk) begin
            if (!resetn) in_f = 1'b0;
            else begin
                if (busy_s[g] === 1'b1) busy_cnt[g]++;
                if (!in_f && done_s[g] !== 1'b0) stray[g]++;
                if (!in_f && tx_s[g] === 1'b0) begin
                    in_f = 1'b1;
                    n = 0;
                    act = '1;
                    done_n = 0;
                    busy_ok = 1'b1;
                    starts[g].push_back(cyc);
                end
                if (in_f) begin
                    act[n] = tx_s[g];
                    if (busy_s[g] !== 1'b1) busy_ok = 1'b0;
                    if (done_s[g] === 1'b1) begin
                        done_n = (done_n == 0) ? n + 1 : -1;
                        dones[g].push_back(cyc);
                    end
                    n++;
                    if (n == FL) begin
                        in_f = 1'b0;
                        if (exp_q[g].size() == 0) chk("unexpected_frame", 1, 0);
                        else begin
                            b = exp_q[g].pop_front();
                            chk("frame_bits", act, exp_frame(b, FL));
                            chk("done_position", done_n, FL);
                            chk("busy_in_frame", busy_ok, 1);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] b, output int acc);
        int t = 0;
        d_s[g] = b;
        valid_s[g] = 1'b1;
        while (ready_s[g] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        acc = cyc + 1;
        if (t >= 400) chk("send_timeout", 1, 0);
        else exp_q[g].push_back(b);
        @(negedge clk);
        valid_s[g] = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy_s[0] !== 1'b0 || busy_s[1] !== 1'b0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int k;
        for (int i = 0; i < 2; i++) begin
            d_s[i] = '0;
            valid_s[i] = 1'b0;
            busy_cnt[i] = 0;
            stray[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_tx", tx_s[i], 1);
            chk("reset_ready", ready_s[i], 1);
            chk("reset_busy", busy_s[i], 0);
            chk("reset_done", done_s[i], 0);
        end
        resetn = 1'b1;
        @(negedge clk);

        busy_cnt[0] = 0;
        send(0, 8'hA5, a);
        wait_idle();
        chk("a5_frames", starts[0].size(), 1);
        chk("a5_latency", starts[0][0] - a, 1);
        chk("a5_busy_cycles", busy_cnt[0], 40);
        chk("a5_done_count", dones[0].size(), 1);
        chk("a5_done_cycle", dones[0][0] - starts[0][0], 39);

        starts[0].delete();
        dones[0].delete();
        send(0, 8'h00, a);
        send(0, 8'hFF, a);
        repeat (20) @(negedge clk);
        chk("b2b_ready_held", ready_s[0], 0);
        wait_idle();
        chk("b2b_frames", starts[0].size(), 2);
        chk("b2b_no_gap", starts[0][1] - starts[0][0], 40);
        chk("b2b_done_spacing", dones[0][1] - dones[0][0], 40);

        send(1, 8'h3C, a);
        wait_idle();
        chk("stop2_frames", starts[1].size(), 1);
        chk("stop2_done_cycle", dones[1][0] - starts[1][0], 43);

        starts[0].delete();
        d_s[0] = 8'h01;
        valid_s[0] = 1'b1;
        k = 0;
        for (int t = 0; t < 600 && k < 3; t++) begin
            if (ready_s[0] === 1'b1) begin
                exp_q[0].push_back(d_s[0]);
                k++;
                @(negedge clk);
                d_s[0] = d_s[0] + 8'h01;
            end else @(negedge clk);
        end
        valid_s[0] = 1'b0;
        chk("stream_accepts", k, 3);
        wait_idle();
        chk("stream_frames", starts[0].size(), 3);
        if (starts[0].size() == 3) chk("stream_span", starts[0][2] - starts[0][0], 80);

        for (int i = 0; i < 10; i++) begin
            send(int'($urandom_range(0, 1)), 8'($urandom), a);
            repeat ($urandom_range(0, 45)) @(negedge clk);
        end
        wait_idle();

        dones[0].delete();
        send(0, 8'h55, a);
        send(0, 8'hAA, a);
        repeat (16) @(negedge clk);
        chk("rst_midframe_busy", busy_s[0], 1);
        #2 resetn = 1'b0;
        exp_q[0].delete();
        #1;
        chk("async_rst_tx", tx_s[0], 1);
        chk("async_rst_ready", ready_s[0], 1);
        chk("async_rst_busy", busy_s[0], 0);
        chk("async_rst_done", done_s[0], 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        starts[0].delete();
        repeat (60) @(negedge clk);
        chk("rst_hold_dropped", starts[0].size(), 0);
        chk("rst_no_done", dones[0].size(), 0);
        send(0, 8'h0F, a);
        wait_idle();
        chk("post_rst_frames", starts[0].size(), 1);
        chk("post_rst_done_cycle", dones[0][0] - starts[0][0], 39);

        for (int i = 0; i < 2; i++) begin
            chk("queue_drained", exp_q[i].size(), 0);
            chk("stray_done", stray[i], 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
